// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared LEGv8 decode constants: register conventions and field positions
package cpu_pkg;

    // Register conventions
    localparam int ZERO_REG_DEF = 31;
    localparam int LINK_REG_DEF = 30;

    // Instruction field positions (register indices are always 5 bits wide in the encoding)
    localparam int IDX_W     = 5;
    localparam int RT_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int RM_LSB    = 16;
    localparam int IMM9_LSB  = 12;
    localparam int IMM9_W    = 9;
    localparam int IMM12_LSB = 10;
    localparam int IMM12_W   = 12;
    localparam int BR26_LSB  = 0;
    localparam int BR26_W    = 26;
    localparam int CB19_LSB  = 5;
    localparam int CB19_W    = 19;

    // Control bundle field positions; the bundle is opaque to decode and consumed by EX
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_BRANCH     = 7;
    localparam int CTRL_UNCOND     = 8;

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - register file with one write port and two write-bypassed read ports
// Ports: clk/reset (async, active-high); wb_en/wb_link/wb_addr/wb_data write port;
//        ra1/ra2 read indices; rd1/rd2 combinational read data (ZERO_REG reads 0).
module regfile_bypass #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31,
    parameter int LINK_REG = 30,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic              wb_link,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    localparam int NPHYS = NREGS - 1;
    localparam int PW    = (NPHYS > 1) ? $clog2(NPHYS) : 1;
    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
    localparam logic [AW-1:0] LR = AW'(LINK_REG);

    logic [DATA_W-1:0] mem_q [NPHYS];
    logic [DATA_W-1:0] mem_d [NPHYS];
    logic [AW-1:0]     wa;
    logic              wr;

    // The zero register has no storage: indices above it shift down by one.
    function automatic logic [PW-1:0] phys(input logic [AW-1:0] idx);
        logic [AW-1:0] p;
        p = (idx < ZR) ? idx : idx - AW'(1);
        return PW'(p);
    endfunction

    assign wa = wb_link ? LR : wb_addr;
    assign wr = wb_en && (wa != ZR);

    always_comb begin
        mem_d = mem_q;
        if (wr) begin
            mem_d[phys(wa)] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPHYS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Same-cycle bypass replaces the old negedge write: the value being written is visible now.
    assign rd1 = (ra1 == ZR) ? '0 : (wr && wa == ra1) ? wb_data : mem_q[phys(ra1)];
    assign rd2 = (ra2 == ZR) ? '0 : (wr && wa == ra2) ? wb_data : mem_q[phys(ra2)];

endmodule

// File: rtl/sign_ext.sv
// rtl/sign_ext.sv - sign extension of an IN_W field to OUT_W bits
// Ports: din (IN_W) field to extend; dout (OUT_W) sign-extended result.
module sign_ext #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 64
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);
    assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
endmodule

// File: rtl/zero_ext.sv
// rtl/zero_ext.sv - zero extension of an IN_W field to OUT_W bits
// Ports: din (IN_W) field to extend; dout (OUT_W) zero-extended result.
module zero_ext #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 64
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);
    assign dout = {{(OUT_W-IN_W){1'b0}}, din};
endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - LEGv8 decode stage: regfile read with bypass, immediates, load-use stall, ID/EX register
// Ports: clk/reset (async, active-high); IF/ID inputs (if_valid, instr, pc, ctrl_in, reg2loc,
//        uses_rn, uses_rm, uncond_in, mem_read_in, reg_write_in); flush; write-back port
//        (wb_en, wb_link, wb_addr, wb_data); stall (combinational); registered ex_* outputs;
//        saturating stall_cnt / flush_cnt.
module id_stage_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int CTRL_W   = 16,
    parameter int CNT_W    = 16,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              reg2loc,
    input  logic              uses_rn,
    input  logic              uses_rm,
    input  logic              uncond_in,
    input  logic              mem_read_in,
    input  logic              reg_write_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic              wb_link,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm9,
    output logic [DATA_W-1:0] ex_imm12,
    output logic [DATA_W-1:0] ex_br_target,
    output logic [AW-1:0]     ex_rn,
    output logic [AW-1:0]     ex_rm,
    output logic [AW-1:0]     ex_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              reg_write;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm9;
        logic [DATA_W-1:0] imm12;
        logic [DATA_W-1:0] br_target;
        logic [AW-1:0]     rn;
        logic [AW-1:0]     rm;
        logic [AW-1:0]     rd;
    } idex_t;

    idex_t ex_d, ex_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    logic [AW-1:0]     rn, rm_sel, rd_idx;
    logic [DATA_W-1:0] rd1, rd2, imm9, imm12, br26_ext, cb19_ext, br_target;
    logic              hazard;
    logic              unused_instr;

    assign unused_instr = ^instr[31:26];

    assign rn     = AW'(instr[RN_LSB +: IDX_W]);
    assign rm_sel = reg2loc ? AW'(instr[RM_LSB +: IDX_W]) : AW'(instr[RT_LSB +: IDX_W]);
    assign rd_idx = AW'(instr[RT_LSB +: IDX_W]);

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .LINK_REG (LINK_REG)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_link (wb_link),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra1     (rn),
        .ra2     (rm_sel),
        .rd1     (rd1),
        .rd2     (rd2)
    );

    sign_ext #(.IN_W(IMM9_W),  .OUT_W(DATA_W)) u_imm9  (.din(instr[IMM9_LSB +: IMM9_W]),   .dout(imm9));
    zero_ext #(.IN_W(IMM12_W), .OUT_W(DATA_W)) u_imm12 (.din(instr[IMM12_LSB +: IMM12_W]), .dout(imm12));
    sign_ext #(.IN_W(BR26_W),  .OUT_W(DATA_W)) u_br26  (.din(instr[BR26_LSB +: BR26_W]),   .dout(br26_ext));
    sign_ext #(.IN_W(CB19_W),  .OUT_W(DATA_W)) u_cb19  (.din(instr[CB19_LSB +: CB19_W]),   .dout(cb19_ext));

    // Offsets are word counts; the shift drops the top bits so the sum wraps modulo 2^DATA_W.
    assign br_target = pc + ((uncond_in ? br26_ext : cb19_ext) << 2);

    // A load in EX whose destination is read by the instruction in ID must wait one cycle.
    assign hazard = if_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != ZR) &&
                    ((uses_rn && rn == ex_q.rd) || (uses_rm && rm_sel == ex_q.rd));
    // A taken branch kills the dependent instruction anyway, so there is nothing to hold.
    assign stall = hazard && !flush;

    always_comb begin
        ex_d = '0;
        if (!flush && !stall) begin
            ex_d.valid     = if_valid;
            ex_d.mem_read  = mem_read_in;
            ex_d.reg_write = reg_write_in;
            ex_d.ctrl      = ctrl_in;
            ex_d.pc        = pc;
            ex_d.rd1       = rd1;
            ex_d.rd2       = rd2;
            ex_d.imm9      = imm9;
            ex_d.imm12     = imm12;
            ex_d.br_target = br_target;
            ex_d.rn        = rn;
            ex_d.rm        = rm_sel;
            ex_d.rd        = rd_idx;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && if_valid && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_pc        = ex_q.pc;
    assign ex_rd1       = ex_q.rd1;
    assign ex_rd2       = ex_q.rd2;
    assign ex_imm9      = ex_q.imm9;
    assign ex_imm12     = ex_q.imm12;
    assign ex_br_target = ex_q.br_target;
    assign ex_rn        = ex_q.rn;
    assign ex_rm        = ex_q.rm;
    assign ex_rd        = ex_q.rd;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard bench for id_stage_pipe
module tb_id_stage_pipe;

    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;
    logic [15:0] ctrl_in = '0;
    logic        reg2loc = 1'b0, uses_rn = 1'b0, uses_rm = 1'b0, uncond_in = 1'b0;
    logic        mem_read_in = 1'b0, reg_write_in = 1'b0, flush = 1'b0;
    logic        wb_en = 1'b0, wb_link = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;

    logic        stall, ex_valid, ex_mem_read, ex_reg_write;
    logic [15:0] ex_ctrl;
    logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm9, ex_imm12, ex_br_target;
    logic [4:0]  ex_rn, ex_rm, ex_rd;
    logic [CW-1:0] stall_cnt, flush_cnt;

    id_stage_pipe #(
        .DATA_W (64),
        .NREGS  (32),
        .CTRL_W (16),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .instr        (instr),
        .pc           (pc),
        .ctrl_in      (ctrl_in),
        .reg2loc      (reg2loc),
        .uses_rn      (uses_rn),
        .uses_rm      (uses_rm),
        .uncond_in    (uncond_in),
        .mem_read_in  (mem_read_in),
        .reg_write_in (reg_write_in),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_link      (wb_link),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_ctrl      (ex_ctrl),
        .ex_pc        (ex_pc),
        .ex_rd1       (ex_rd1),
        .ex_rd2       (ex_rd2),
        .ex_imm9      (ex_imm9),
        .ex_imm12     (ex_imm12),
        .ex_br_target (ex_br_target),
        .ex_rn        (ex_rn),
        .ex_rm        (ex_rm),
        .ex_rd        (ex_rd),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        if_valid;
        bit [31:0] instr;
        bit [63:0] pc;
        bit [15:0] ctrl;
        bit        reg2loc, uses_rn, uses_rm, uncond, mem_read, reg_write, flush;
        bit        wb_en, wb_link;
        bit [4:0]  wb_addr;
        bit [63:0] wb_data;
    } stim_t;

    typedef struct packed {
        bit        valid, mem_read, reg_write;
        bit [15:0] ctrl;
        bit [63:0] pc, rd1, rd2, imm9, imm12, br;
        bit [4:0]  rn, rm, rd;
        bit [CW-1:0] sc, fc;
    } exp_t;

    int checks = 0;
    int failures = 0;

    exp_t      exq[$];
    bit [63:0] regs [32];
    exp_t      ex_m;
    int        sc_m, fc_m;
    int        sat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] mk(input bit [4:0] rn, input bit [4:0] rm, input bit [4:0] rd);
        return {11'h0, rm, 6'h0, rn, rd};
    endfunction

    function automatic bit [63:0] rd_model(input stim_t st, input bit [4:0] idx);
        bit [4:0] wa;
        wa = st.wb_link ? 5'd30 : st.wb_addr;
        if (idx == 5'd31) return 64'd0;
        if (st.wb_en && wa == idx) return st.wb_data;
        return regs[idx];
    endfunction

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_mem_read", ex_mem_read, 0);
        chk("rst_ex_reg_write", ex_reg_write, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_rd1", ex_rd1, 0);
        chk("rst_ex_rd2", ex_rd2, 0);
        chk("rst_ex_imm9", ex_imm9, 0);
        chk("rst_ex_imm12", ex_imm12, 0);
        chk("rst_ex_br_target", ex_br_target, 0);
        chk("rst_ex_rn", ex_rn, 0);
        chk("rst_ex_rm", ex_rm, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        for (int i = 0; i < 32; i++) regs[i] = '0;
        ex_m = '0;
        sc_m = 0;
        fc_m = 0;
        @(posedge clk);
    endtask

    // Drive one ID cycle and push what EX must hold after the following edge.
    task automatic step(input stim_t st);
        exp_t     e;
        bit [4:0] rn, rm, rd, wa;
        bit       haz, stl;
        longint   s;
        @(negedge clk);
        reset        = 1'b0;
        if_valid     = st.if_valid;
        instr        = st.instr;
        pc           = st.pc;
        ctrl_in      = st.ctrl;
        reg2loc      = st.reg2loc;
        uses_rn      = st.uses_rn;
        uses_rm      = st.uses_rm;
        uncond_in    = st.uncond;
        mem_read_in  = st.mem_read;
        reg_write_in = st.reg_write;
        flush        = st.flush;
        wb_en        = st.wb_en;
        wb_link      = st.wb_link;
        wb_addr      = st.wb_addr;
        wb_data      = st.wb_data;
        #1;
        rn  = st.instr[9:5];
        rm  = st.reg2loc ? st.instr[20:16] : st.instr[4:0];
        rd  = st.instr[4:0];
        haz = st.if_valid && ex_m.valid && ex_m.mem_read && (ex_m.rd != 5'd31) &&
              ((st.uses_rn && rn == ex_m.rd) || (st.uses_rm && rm == ex_m.rd));
        stl = haz && !st.flush;
        chk("stall", stall, stl);

        e = '0;
        if (!st.flush && !stl) begin
            e.valid     = st.if_valid;
            e.mem_read  = st.mem_read;
            e.reg_write = st.reg_write;
            e.ctrl      = st.ctrl;
            e.pc        = st.pc;
            e.rd1       = rd_model(st, rn);
            e.rd2       = rd_model(st, rm);
            s = longint'(st.instr[20:12]);
            if (s >= 256) s -= 512;
            e.imm9  = s;
            e.imm12 = 64'(st.instr[21:10]);
            if (st.uncond) begin
                s = longint'(st.instr[25:0]);
                if (s >= 2**25) s -= 2**26;
            end else begin
                s = longint'(st.instr[23:5]);
                if (s >= 2**18) s -= 2**19;
            end
            e.br = st.pc + 64'(s * 4);
            e.rn = rn;
            e.rm = rm;
            e.rd = rd;
        end
        if (stl && sc_m < sat) sc_m++;
        if (st.flush && st.if_valid && fc_m < sat) fc_m++;
        e.sc = CW'(sc_m);
        e.fc = CW'(fc_m);

        wa = st.wb_link ? 5'd30 : st.wb_addr;
        if (st.wb_en && wa != 5'd31) regs[wa] = st.wb_data;
        ex_m = e;
        exq.push_back(e);
    endtask

    function automatic bit [4:0] pick();
        case ($urandom_range(0, 5))
            0:       return 5'd31;
            1:       return 5'd30;
            default: return 5'($urandom_range(0, 4));
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t st;
        st           = '0;
        st.if_valid  = ($urandom_range(0, 9) != 0);
        st.instr     = $urandom;
        st.instr[9:5]   = pick();
        st.instr[20:16] = pick();
        st.instr[4:0]   = pick();
        st.pc        = {$urandom, $urandom};
        st.ctrl      = 16'($urandom);
        st.reg2loc   = 1'($urandom);
        st.uses_rn   = 1'($urandom);
        st.uses_rm   = 1'($urandom);
        st.uncond    = 1'($urandom);
        st.mem_read  = ($urandom_range(0, 2) == 0);
        st.reg_write = 1'($urandom);
        st.flush     = ($urandom_range(0, 9) == 0);
        st.wb_en     = 1'($urandom);
        st.wb_link   = ($urandom_range(0, 7) == 0);
        st.wb_addr   = pick();
        st.wb_data   = {$urandom, $urandom};
        return st;
    endfunction

    // Monitor: compares every post-edge EX state against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) continue;
            if (exq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL monitor: EX update with no expectation at %0t", $time);
            end else begin
                e = exq.pop_front();
                chk("ex_valid", ex_valid, e.valid);
                chk("ex_mem_read", ex_mem_read, e.mem_read);
                chk("ex_reg_write", ex_reg_write, e.reg_write);
                chk("ex_ctrl", ex_ctrl, e.ctrl);
                chk("ex_pc", ex_pc, e.pc);
                chk("ex_rd1", ex_rd1, e.rd1);
                chk("ex_rd2", ex_rd2, e.rd2);
                chk("ex_imm9", ex_imm9, e.imm9);
                chk("ex_imm12", ex_imm12, e.imm12);
                chk("ex_br_target", ex_br_target, e.br);
                chk("ex_rn", ex_rn, e.rn);
                chk("ex_rm", ex_rm, e.rm);
                chk("ex_rd", ex_rd, e.rd);
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t st;
        stim_t ld;
        stim_t use_rm;
        sat = (1 << CW) - 1;

        do_reset();

        // Write X1, then read it
        st = '0; st.wb_en = 1; st.wb_addr = 5'd1; st.wb_data = 64'h55;
        step(st);
        st = '0; st.if_valid = 1; st.instr = mk(5'd1, 5'd0, 5'd7); st.uses_rn = 1;
        step(st);
        after_edge();
        chk("dir_x1_read", ex_rd1, 64'h55);

        // Same-cycle bypass
        st = '0; st.if_valid = 1; st.instr = mk(5'd3, 5'd0, 5'd8); st.uses_rn = 1;
        st.wb_en = 1; st.wb_addr = 5'd3; st.wb_data = 64'hA5;
        step(st);
        after_edge();
        chk("dir_bypass", ex_rd1, 64'hA5);

        // Writes to X31 are dropped
        st = '0; st.wb_en = 1; st.wb_addr = 5'd31; st.wb_data = 64'hFFFF;
        step(st);
        st = '0; st.if_valid = 1; st.instr = mk(5'd31, 5'd0, 5'd0);
        step(st);
        after_edge();
        chk("dir_x31_zero", ex_rd1, 64'h0);

        // wb_link redirects the write to X30
        st = '0; st.wb_en = 1; st.wb_link = 1; st.wb_addr = 5'd5; st.wb_data = 64'h40;
        step(st);
        st = '0; st.if_valid = 1; st.instr = mk(5'd30, 5'd5, 5'd0); st.reg2loc = 1;
        step(st);
        after_edge();
        chk("dir_link_x30", ex_rd1, 64'h40);
        chk("dir_link_x5", ex_rd2, 64'h0);

        // Load-use: one-cycle stall then release
        ld = '0; ld.if_valid = 1; ld.mem_read = 1; ld.reg_write = 1; ld.instr = mk(5'd1, 5'd0, 5'd2);
        use_rm = '0; use_rm.if_valid = 1; use_rm.reg2loc = 1; use_rm.uses_rm = 1; use_rm.instr = mk(5'd4, 5'd2, 5'd9);
        step(ld);
        step(use_rm);
        chk("dir_lu_stall", stall, 1);
        after_edge();
        chk("dir_lu_bubble", ex_valid, 0);
        chk("dir_lu_cnt", stall_cnt, 1);
        step(use_rm);
        chk("dir_lu_release", stall, 0);
        after_edge();
        chk("dir_lu_issue", ex_valid, 1);

        // Hazard together with flush: flush wins
        step(ld);
        st = use_rm; st.flush = 1;
        step(st);
        chk("dir_fl_stall", stall, 0);
        after_edge();
        chk("dir_fl_bubble", ex_valid, 0);
        chk("dir_fl_cnt", flush_cnt, 1);
        chk("dir_fl_stall_cnt", stall_cnt, 1);

        // Counter saturation
        for (int i = 0; i < 8; i++) begin
            step(ld);
            step(use_rm);
        end
        after_edge();
        chk("dir_sat", stall_cnt, 64'(sat));

        // Branch targets
        st = '0; st.if_valid = 1; st.uncond = 1; st.pc = 64'h100; st.instr = 32'h03FF_FFFF;
        step(st);
        after_edge();
        chk("dir_b_target", ex_br_target, 64'hFC);
        st = '0; st.if_valid = 1; st.uncond = 0; st.pc = 64'h100; st.instr = {8'h0, 19'd4, 5'd0};
        step(st);
        after_edge();
        chk("dir_cbz_target", ex_br_target, 64'h110);

        // Mid-stream reset
        do_reset();

        // Randomised stream with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            else step(rand_stim());
        end
        after_edge();
        chk("queue_drained", 64'(exq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised decode stage for the pipelined LEGv8 CPU. It combines the register file, operand read with write-back bypass, immediate and branch-target generation, load-use hazard detection and the registered ID/EX pipeline boundary. It sits between the IF/ID register and the execute stage. It replaces the negedge-clocked register file write with a same-cycle bypass, and it adds stall, flush and saturating event counters.

Parameters:
DATA_W, 64, datapath and register width
NREGS, 32, architectural register count; AW = $clog2(NREGS) is derived and not overridable
ZERO_REG, 31, register index hard-wired to zero; reads return 0, writes are dropped
LINK_REG, 30, write index forced when wb_link=1
CTRL_W, 16, width of the opaque control bundle passed through to EX
CNT_W, 16, width of the event counters

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high
if_valid  in  1  IF/ID holds a valid instruction
instr  in  32  instruction word
pc  in  DATA_W  PC of instr
ctrl_in  in  CTRL_W  control bundle from control_unit
reg2loc  in  1  1: second read index = instr[20:16]; 0: second read index = instr[4:0]
uses_rn / uses_rm  in  1 each  instruction reads port 1 / port 2
uncond_in  in  1  1: B-type offset instr[25:0]; 0: CB-type offset instr[23:5]
mem_read_in, reg_write_in  in  1 each  load / register-writing instruction
flush  in  1  branch resolved taken; kill the instruction in ID
wb_en  in  1  write-back enable
wb_link  in  1  force write index to LINK_REG
wb_addr  in  AW  write-back index
wb_data  in  DATA_W  write-back data
stall  out  1  combinational; hold PC and IF/ID
ex_valid, ex_mem_read, ex_reg_write  out  1 each
ex_ctrl  out  CTRL_W
ex_pc, ex_rd1, ex_rd2, ex_imm9, ex_imm12, ex_br_target  out  DATA_W each
ex_rn, ex_rm, ex_rd  out  AW each  registered source and destination indices (ex_rd = instr[4:0])
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset is asynchronous; clk and reset only, as decided. On reset, every register-file entry and every ex_* output clears to 0, and both counters clear to 0. stall is combinational and reads 0 while ex_valid=0.
- Register file: NREGS-1 physical entries, written on posedge when wb_en=1 and the effective index is not ZERO_REG. Effective index = wb_link ? LINK_REG : wb_addr.
- Reads are combinational, indexed by rn=instr[9:5] and rm_sel (per reg2loc).
- Bypass: if wb_en=1 and the effective write index equals a read index that is not ZERO_REG, that read returns wb_data in the same cycle.
- Reading ZERO_REG always returns 0.
- Immediates:
  - imm9 = sign-extended instr[20:12].
  - imm12 = zero-extended instr[21:10].
  - br_target = pc + (sign-extended selected offset << 2), computed modulo 2^DATA_W.
- Load-use hazard: stall = if_valid & ex_valid & ex_mem_read & (ex_rd != ZERO_REG) & ((uses_rn & rn==ex_rd) | (uses_rm & rm_sel==ex_rd)) & ~flush.
- ID/EX update priority at each posedge:
  - flush: load a bubble.
  - else stall: load a bubble.
  - else: load the current decode; ex_valid = if_valid.
- A bubble sets ex_valid, ex_mem_read and ex_reg_write to 0 and ex_ctrl to 0. The data fields of a bubble are don't-care but are driven to 0.
- A stall lasts exactly one cycle per load-use pair, because the load leaves EX on the next edge.
- flush asserted together with a hazard: flush wins, stall=0, one bubble.
- Counters: stall_cnt increments on each posedge where stall=1; flush_cnt increments on each posedge where flush=1 and if_valid=1. Both saturate at all-ones and never wrap.
- Reset asserted mid-operation clears everything immediately; the first valid decode appears on the first posedge after release.
- Latency: one cycle from ID inputs to ex_* outputs.

Decomposition:
- Shared package cpu_pkg: ZERO_REG and LINK_REG defaults, and the field positions of the control bundle and instruction (RN_LSB, RM_LSB, RT_LSB, IMM9/IMM12/BR26/CB19 ranges).
- One sub-module, regfile_bypass (parametrised on DATA_W and NREGS), holding the storage, the write port and the two bypassed read ports.
- Reuse the existing sign_ext and zero_ext blocks.

Test Plan:
- Reset, then write X1=0x55 and read instr with rn=1, uses_rn=1 → ex_rd1=0x55 one cycle later.
- Same-cycle bypass: wb_en=1, wb_addr=3, wb_data=0xA5, with the decode reading rn=3 in the same cycle → ex_rd1=0xA5 at the next edge.
- Write X31=0xFFFF, then read X31 → 0. With wb_link=1, wb_addr=5, data=0x40 → X30=0x40 and X5 unchanged.
- Load to X2 in EX (ex_mem_read=1, ex_rd=2), next instr uses rm=2 → stall=1 for exactly one cycle, bubble inserted (ex_valid=0), stall_cnt=1.
- Load-use hazard with flush=1 in the same cycle → stall=0, bubble, flush_cnt=1. With CNT_W=2, four stalls → stall_cnt stays at 3.
- B with instr[25:0]=0x3FFFFFF (offset -1), pc=0x100 → ex_br_target=0xFC. CBZ with instr[23:5]=4, pc=0x100 → 0x110. Assert reset mid-stream → all ex_* outputs read 0 immediately.
